// File: rtl/keccak_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | keccak_pkg                                                             |
// | Shared Keccak-f[1600] geometry, SHAKE rates and squeeze FSM states.    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package keccak_pkg;

   localparam int STATE_W       = 1600;
   localparam int LANE_W        = 64;
   localparam int NUM_LANES     = 25;
   localparam int SHAKE128_RATE = 1344;
   localparam int SHAKE256_RATE = 1088;

   typedef enum logic [1:0] {
      SQ_IDLE      = 2'd0,
      SQ_WAIT_PERM = 2'd1,
      SQ_STREAM    = 2'd2
   } sq_state_e;

endpackage
`default_nettype wire

// File: rtl/shake_squeeze.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | shake_squeeze                                                          |
// | Captures permuted Keccak states and streams the rate as output words,  |
// | requesting a fresh permutation whenever the rate is exhausted.        |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module shake_squeeze
   import keccak_pkg::*;
#(
   parameter int RATE_BITS = SHAKE128_RATE,
   parameter int WORD_W    = LANE_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic [STATE_W-1:0]  state_in,
   input  logic                state_valid,
   output logic                perm_req,
   output logic [STATE_W-1:0]  perm_state,
   output logic [WORD_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          block_cnt,
   output logic                busy
);

   localparam int WORDS = RATE_BITS / WORD_W;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   sq_state_e          state_q;
   logic               state_valid_q;
   logic [STATE_W-1:0] buffer_q;
   logic [IDX_W-1:0]   word_idx_q;
   logic [7:0]         block_cnt_q;
   logic               out_valid_q;
   logic               perm_req_q;
   logic               busy_q;
   logic               accept;

   // Only a fresh rising edge of the core's valid captures a state.
   assign accept = state_valid & ~state_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= SQ_IDLE;
         state_valid_q <= 1'b0;
         buffer_q      <= '0;
         word_idx_q    <= '0;
         block_cnt_q   <= 8'd0;
         out_valid_q   <= 1'b0;
         perm_req_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_valid_q <= state_valid;
         perm_req_q    <= 1'b0;
         case (state_q)
            SQ_IDLE: begin
               if (start) begin
                  state_q     <= SQ_WAIT_PERM;
                  block_cnt_q <= 8'd0;
                  busy_q      <= 1'b1;
               end
            end
            SQ_WAIT_PERM: begin
               if (stop) begin
                  state_q <= SQ_IDLE;
                  busy_q  <= 1'b0;
               end else if (accept) begin
                  buffer_q    <= state_in;
                  word_idx_q  <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= SQ_STREAM;
                  if (block_cnt_q != 8'hFF) begin
                     block_cnt_q <= block_cnt_q + 8'd1;
                  end
               end
            end
            SQ_STREAM: begin
               // stop wins over a same-cycle handshake: that word is dropped unconsumed.
               if (stop) begin
                  state_q     <= SQ_IDLE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b0;
               end else if (out_ready) begin
                  if (word_idx_q == LAST_IDX) begin
                     perm_req_q  <= 1'b1;
                     out_valid_q <= 1'b0;
                     state_q     <= SQ_WAIT_PERM;
                  end else begin
                     word_idx_q <= word_idx_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_q     <= SQ_IDLE;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_data   = buffer_q[int'(word_idx_q) * WORD_W +: WORD_W];
   assign perm_state = buffer_q;
   assign out_valid  = out_valid_q;
   assign perm_req   = perm_req_q;
   assign block_cnt  = block_cnt_q;
   assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_shake_squeeze.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_shake_squeeze                                                       |
// | Directed self-checking bench for SHAKE128 and SHAKE256 squeeze builds. |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_shake_squeeze;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // SHAKE128 (default) instance
   logic          rst, start, stop, state_valid, out_ready;
   logic [1599:0] state_in;
   logic          perm_req, out_valid, busy;
   logic [1599:0] perm_state;
   logic [63:0]   out_data;
   logic [7:0]    block_cnt;

   // SHAKE256 instance
   logic          b_rst, b_start, b_stop, b_state_valid, b_out_ready;
   logic [1599:0] b_state_in;
   logic          b_perm_req, b_out_valid, b_busy;
   logic [1599:0] b_perm_state;
   logic [63:0]   b_out_data;
   logic [7:0]    b_block_cnt;

   int n_cmp = 0;
   int n_err = 0;

   shake_squeeze #(.RATE_BITS(1344), .WORD_W(64)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .state_in(state_in), .state_valid(state_valid),
      .perm_req(perm_req), .perm_state(perm_state),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .block_cnt(block_cnt), .busy(busy)
   );

   shake_squeeze #(.RATE_BITS(1088), .WORD_W(64)) dut256 (
      .clk(clk), .rst(b_rst), .start(b_start), .stop(b_stop),
      .state_in(b_state_in), .state_valid(b_state_valid),
      .perm_req(b_perm_req), .perm_state(b_perm_state),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .block_cnt(b_block_cnt), .busy(b_busy)
   );

   function automatic logic [1599:0] mk_state(input logic [63:0] base);
      logic [1599:0] s;
      for (int i = 0; i < 25; i++) s[i*64 +: 64] = base + 64'(i);
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] A5 = 64'hA5A5_0000_0000_0000;
   localparam logic [63:0] FA = 64'h5A5A_0000_0000_0000;
   localparam logic [63:0] C3 = 64'hC3C3_0000_0000_0000;
   localparam logic [63:0] D4 = 64'h3C3C_0000_0000_0000;

   task automatic test_reset();
      rst = 1'b1; b_rst = 1'b1;
      start = 1'(($urandom)); stop = 1'($urandom); state_valid = 1'($urandom); out_ready = 1'($urandom);
      for (int i = 0; i < 50; i++) state_in[i*32 +: 32] = $urandom;
      b_start = 1'($urandom); b_stop = 1'($urandom); b_state_valid = 1'($urandom); b_out_ready = 1'($urandom);
      b_state_in = state_in;
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
      n_cmp++; if (perm_req !== 1'b0) begin n_err++; $display("FAIL rst_perm_req got %0b exp 0", perm_req); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b exp 0", busy); end
      n_cmp++; if (block_cnt !== 8'd0) begin n_err++; $display("FAIL rst_block_cnt got %0d exp 0", block_cnt); end
      n_cmp++; if (perm_state !== '0) begin n_err++; $display("FAIL rst_perm_state got lane0 %h exp 0", perm_state[63:0]); end
      n_cmp++; if (out_data !== 64'd0) begin n_err++; $display("FAIL rst_out_data got %h exp 0", out_data); end
      rst = 1'b0; start = 1'b0; stop = 1'b0; state_valid = 1'b0; out_ready = 1'b0;
      b_rst = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_state_valid = 1'b0; b_out_ready = 1'b0;
      state_in = mk_state(FA);
      tick();
      for (int k = 0; k < 3; k++) begin
         state_valid = 1'b1; stop = (k == 1); tick();
         state_valid = 1'b0; stop = 1'b0; tick();
      end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid got %0b exp 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %0b exp 0", busy); end
      n_cmp++; if (block_cnt !== 8'd0) begin n_err++; $display("FAIL idle_block_cnt got %0d exp 0", block_cnt); end
      n_cmp++; if (perm_state !== '0) begin n_err++; $display("FAIL idle_perm_state got lane0 %h exp 0", perm_state[63:0]); end
   endtask

   task automatic test_full_block();
      logic [1599:0] exp_st;
      exp_st = mk_state(A5);
      start = 1'b1; tick(); start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fb_busy got %0b exp 1", busy); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fb_wait_valid got %0b exp 0", out_valid); end
      state_in = exp_st; state_valid = 1'b1; out_ready = 1'b1;
      tick();
      n_cmp++; if (block_cnt !== 8'd1) begin n_err++; $display("FAIL fb_block_cnt got %0d exp 1", block_cnt); end
      for (int w = 0; w < 21; w++) begin
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fb_valid w%0d got %0b exp 1", w, out_valid); end
         n_cmp++; if (out_data !== A5 + 64'(w)) begin n_err++; $display("FAIL fb_data w%0d got %h exp %h", w, out_data, A5 + 64'(w)); end
         n_cmp++; if (perm_req !== 1'b0) begin n_err++; $display("FAIL fb_early_perm_req w%0d got %0b exp 0", w, perm_req); end
         tick();
      end
      n_cmp++; if (perm_req !== 1'b1) begin n_err++; $display("FAIL fb_perm_req got %0b exp 1", perm_req); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fb_valid_after got %0b exp 0", out_valid); end
      n_cmp++; if (perm_state !== exp_st) begin n_err++; $display("FAIL fb_perm_state got lane0 %h lane24 %h exp lane0 %h lane24 %h", perm_state[63:0], perm_state[1599:1536], exp_st[63:0], exp_st[1599:1536]); end
      tick();
      n_cmp++; if (perm_req !== 1'b0) begin n_err++; $display("FAIL fb_perm_req_pulse got %0b exp 0", perm_req); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fb_busy_wait got %0b exp 1", busy); end
   endtask

   task automatic test_backpressure();
      stop = 1'b1; state_valid = 1'b0; tick(); stop = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_stop_busy got %0b exp 0", busy); end
      start = 1'b1; tick(); start = 1'b0;
      state_in = mk_state(A5); state_valid = 1'b1; out_ready = 1'b1;
      tick();
      n_cmp++; if (block_cnt !== 8'd1) begin n_err++; $display("FAIL bp_block_cnt got %0d exp 1", block_cnt); end
      tick(); tick(); tick();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         n_cmp++; if (out_data !== A5 + 64'd3) begin n_err++; $display("FAIL bp_hold c%0d got %h exp %h", c, out_data, A5 + 64'd3); end
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d got %0b exp 1", c, out_valid); end
         n_cmp++; if (perm_req !== 1'b0) begin n_err++; $display("FAIL bp_perm_req c%0d got %0b exp 0", c, perm_req); end
         tick();
      end
      n_cmp++; if (out_data !== A5 + 64'd3) begin n_err++; $display("FAIL bp_hold_end got %h exp %h", out_data, A5 + 64'd3); end
      out_ready = 1'b1; tick();
      for (int w = 4; w < 21; w++) begin
         n_cmp++; if (out_data !== A5 + 64'(w)) begin n_err++; $display("FAIL bp_resume w%0d got %h exp %h", w, out_data, A5 + 64'(w)); end
         tick();
      end
      n_cmp++; if (perm_req !== 1'b1) begin n_err++; $display("FAIL bp_perm_req got %0b exp 1", perm_req); end
   endtask

   task automatic test_second_block();
      state_in = mk_state(FA);
      tick(); tick(); tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sb_sticky_valid got %0b exp 0", out_valid); end
      n_cmp++; if (block_cnt !== 8'd1) begin n_err++; $display("FAIL sb_sticky_cnt got %0d exp 1", block_cnt); end
      n_cmp++; if (perm_req !== 1'b0) begin n_err++; $display("FAIL sb_sticky_perm_req got %0b exp 0", perm_req); end
      n_cmp++; if (perm_state !== mk_state(A5)) begin n_err++; $display("FAIL sb_sticky_buffer got lane0 %h exp %h", perm_state[63:0], A5); end
      state_valid = 1'b0; tick();
      state_valid = 1'b1; tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sb_valid got %0b exp 1", out_valid); end
      n_cmp++; if (out_data !== FA) begin n_err++; $display("FAIL sb_data got %h exp %h", out_data, FA); end
      n_cmp++; if (block_cnt !== 8'd2) begin n_err++; $display("FAIL sb_block_cnt got %0d exp 2", block_cnt); end
   endtask

   task automatic test_stop();
      for (int w = 0; w < 7; w++) tick();
      n_cmp++; if (out_data !== FA + 64'd7) begin n_err++; $display("FAIL st_word7 got %h exp %h", out_data, FA + 64'd7); end
      stop = 1'b1; tick(); stop = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL st_valid got %0b exp 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL st_busy got %0b exp 0", busy); end
      n_cmp++; if (perm_req !== 1'b0) begin n_err++; $display("FAIL st_perm_req got %0b exp 0", perm_req); end
      n_cmp++; if (block_cnt !== 8'd2) begin n_err++; $display("FAIL st_block_cnt got %0d exp 2", block_cnt); end
      tick();
      n_cmp++; if (perm_req !== 1'b0) begin n_err++; $display("FAIL st_perm_req_late got %0b exp 0", perm_req); end
      state_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
      state_in = mk_state(A5); state_valid = 1'b1; tick();
      n_cmp++; if (out_data !== A5) begin n_err++; $display("FAIL st_restart_data got %h exp %h", out_data, A5); end
      n_cmp++; if (block_cnt !== 8'd1) begin n_err++; $display("FAIL st_restart_cnt got %0d exp 1", block_cnt); end
   endtask

   task automatic test_rate256();
      b_start = 1'b1; tick(); b_start = 1'b0;
      b_state_in = mk_state(C3); b_state_valid = 1'b1; b_out_ready = 1'b1;
      tick();
      for (int w = 0; w < 17; w++) begin
         n_cmp++; if (b_out_data !== C3 + 64'(w)) begin n_err++; $display("FAIL r256_data w%0d got %h exp %h", w, b_out_data, C3 + 64'(w)); end
         n_cmp++; if (b_perm_req !== 1'b0) begin n_err++; $display("FAIL r256_early_perm_req w%0d got %0b exp 0", w, b_perm_req); end
         tick();
      end
      n_cmp++; if (b_perm_req !== 1'b1) begin n_err++; $display("FAIL r256_perm_req got %0b exp 1", b_perm_req); end
      n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL r256_valid_after got %0b exp 0", b_out_valid); end
      b_state_valid = 1'b0; tick();
      b_state_in = mk_state(D4); b_state_valid = 1'b1; tick();
      n_cmp++; if (b_block_cnt !== 8'd2) begin n_err++; $display("FAIL r256_block_cnt got %0d exp 2", b_block_cnt); end
      for (int w = 0; w < 5; w++) tick();
      n_cmp++; if (b_out_data !== D4 + 64'd5) begin n_err++; $display("FAIL r256_word5 got %h exp %h", b_out_data, D4 + 64'd5); end
      b_rst = 1'b1; tick(); b_rst = 1'b0;
      n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL r256_rst_valid got %0b exp 0", b_out_valid); end
      n_cmp++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL r256_rst_busy got %0b exp 0", b_busy); end
      n_cmp++; if (b_block_cnt !== 8'd0) begin n_err++; $display("FAIL r256_rst_cnt got %0d exp 0", b_block_cnt); end
      n_cmp++; if (b_perm_req !== 1'b0) begin n_err++; $display("FAIL r256_rst_perm_req got %0b exp 0", b_perm_req); end
      n_cmp++; if (b_out_data !== 64'd0) begin n_err++; $display("FAIL r256_rst_data got %h exp 0", b_out_data); end
      n_cmp++; if (b_perm_state !== '0) begin n_err++; $display("FAIL r256_rst_perm_state got lane0 %h exp 0", b_perm_state[63:0]); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; state_valid = 1'b0; out_ready = 1'b0; state_in = '0;
      b_rst = 1'b1; b_start = 1'b0; b_stop = 1'b0; b_state_valid = 1'b0; b_out_ready = 1'b0; b_state_in = '0;
      test_reset();
      test_full_block();
      test_backpressure();
      test_second_block();
      test_stop();
      test_rate256();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
